// File: rtl/batcharger_ctrl.sv
// Li-ion charger sequencer: TC -> CC -> CV -> END with temperature guard and recharge restart.
// Optional CV safety timer is enabled by defining BATCHARGER_CTRL_CVTIMER_EN.
module batcharger_ctrl #(
    parameter logic [7:0]  VPRESET = 8'd210,
    parameter logic [7:0]  VCUTOFF = 8'd150,
    parameter logic [7:0]  VRECH   = 8'd200,
    parameter logic [7:0]  TMIN    = 8'd20,
    parameter logic [7:0]  TMAX    = 8'd200,
    parameter logic [15:0] TOUT    = 16'd60000
) (
    input  logic       clk,
    input  logic       rstz,
    input  logic       en,
    input  logic [3:0] sel,
    input  logic       smp_vld,
    input  logic [7:0] vbat,
    input  logic [7:0] ibat,
    input  logic [7:0] tbat,
    output logic [7:0] iset,
    output logic [7:0] vset,
    output logic       imen,
    output logic       vmen,
    output logic       tc,
    output logic       cc,
    output logic       cv,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_TC,
        S_CC,
        S_CV,
        S_END
    } state_t;

    state_t     r_state;
    state_t     w_nextState;
    logic [3:0] r_sel;
    logic [3:0] w_selNext;
    logic [7:0] w_selP1;
    logic [7:0] w_icc;
    logic       w_tok;
    logic       w_timerExp;

    logic [7:0] w_isetNext;
    logic [7:0] w_vsetNext;
    logic       w_imenNext;
    logic       w_vmenNext;
    logic       w_tcNext;
    logic       w_ccNext;
    logic       w_cvNext;
    logic       w_doneNext;

    assign w_selP1 = {4'd0, r_sel} + 8'd1;
    assign w_icc   = w_selP1 << 3;
    assign w_tok   = (tbat >= TMIN) && (tbat <= TMAX);

`ifdef BATCHARGER_CTRL_CVTIMER_EN
    logic [15:0] r_timer;
    logic [15:0] w_timerInc;

    assign w_timerInc = r_timer + 16'd1;
    assign w_timerExp = (w_timerInc >= TOUT);

    // Held at zero outside CV, so every CV entry starts a fresh count.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_timer <= 16'd0;
        end else if (r_state != S_CV) begin
            r_timer <= 16'd0;
        end else if (smp_vld) begin
            r_timer <= w_timerInc;
        end
    end
`else
    // Timer limit is only meaningful in the timer build; tie it off here.
    assign w_timerExp = (TOUT == 16'd0) && 1'b0;
`endif

    always_comb begin
        w_nextState = r_state;
        if (!en) begin
            w_nextState = S_IDLE;
        end else if (smp_vld) begin
            case (r_state)
                S_IDLE:  w_nextState = S_START;
                S_START: begin
                    if (!w_tok)                w_nextState = S_START;
                    else if (vbat < VCUTOFF)   w_nextState = S_TC;
                    else if (vbat < VPRESET)   w_nextState = S_CC;
                    else                       w_nextState = S_END;
                end
                S_TC: begin
                    if (!w_tok)                w_nextState = S_END;
                    else if (vbat >= VCUTOFF)  w_nextState = S_CC;
                end
                S_CC: begin
                    if (!w_tok)                w_nextState = S_END;
                    else if (vbat >= VPRESET)  w_nextState = S_CV;
                end
                S_CV: begin
                    if (!w_tok)                        w_nextState = S_END;
                    else if (ibat <= w_selP1)          w_nextState = S_END;
                    else if (w_timerExp)               w_nextState = S_END;
                end
                S_END: begin
                    if ((vbat < VRECH) && w_tok) w_nextState = S_START;
                end
                default: w_nextState = S_IDLE;
            endcase
        end

        w_selNext = r_sel;
        if ((w_nextState == S_START) && (r_state != S_START)) begin
            w_selNext = sel;
        end

        w_isetNext = 8'd0;
        w_vsetNext = 8'd0;
        w_imenNext = 1'b0;
        w_vmenNext = 1'b0;
        w_tcNext   = 1'b0;
        w_ccNext   = 1'b0;
        w_cvNext   = 1'b0;
        w_doneNext = 1'b0;
        // Setpoints follow the next state so they update on the same edge as the state.
        case (w_nextState)
            S_TC: begin
                w_tcNext   = 1'b1;
                w_imenNext = 1'b1;
                w_isetNext = w_selP1;
            end
            S_CC: begin
                w_ccNext   = 1'b1;
                w_imenNext = 1'b1;
                w_isetNext = w_icc;
            end
            S_CV: begin
                w_cvNext   = 1'b1;
                w_vmenNext = 1'b1;
                w_vsetNext = VPRESET;
            end
            S_END:   w_doneNext = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_state <= S_IDLE;
            r_sel   <= 4'd0;
            iset    <= 8'd0;
            vset    <= 8'd0;
            imen    <= 1'b0;
            vmen    <= 1'b0;
            tc      <= 1'b0;
            cc      <= 1'b0;
            cv      <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_sel   <= w_selNext;
            iset    <= w_isetNext;
            vset    <= w_vsetNext;
            imen    <= w_imenNext;
            vmen    <= w_vmenNext;
            tc      <= w_tcNext;
            cc      <= w_ccNext;
            cv      <= w_cvNext;
            done    <= w_doneNext;
        end
    end

endmodule

// File: tb/tb_batcharger_ctrl.sv
// Directed bench for batcharger_ctrl: charge ramp, recharge, temperature, enable/reset, CV timer, sel hold.
module tb_batcharger_ctrl;

    logic       clk;
    logic       rstz;
    logic       en;
    logic [3:0] sel;
    logic       smp_vld;
    logic [7:0] vbat;
    logic [7:0] ibat;
    logic [7:0] tbat;
    logic [7:0] iset;
    logic [7:0] vset;
    logic       imen;
    logic       vmen;
    logic       tc;
    logic       cc;
    logic       cv;
    logic       done;

    int checks = 0;
    int failures = 0;
    logic [21:0] expv;
    logic [21:0] obs;

    // Flags {tc,cc,cv,done,imen,vmen} then iset, vset.
    assign obs = {tc, cc, cv, done, imen, vmen, iset, vset};

    batcharger_ctrl #(
        .VPRESET(8'd210),
        .VCUTOFF(8'd150),
        .VRECH  (8'd200),
        .TMIN   (8'd20),
        .TMAX   (8'd200),
        .TOUT   (16'd10)
    ) dut (
        .clk    (clk),
        .rstz   (rstz),
        .en     (en),
        .sel    (sel),
        .smp_vld(smp_vld),
        .vbat   (vbat),
        .ibat   (ibat),
        .tbat   (tbat),
        .iset   (iset),
        .vset   (vset),
        .imen   (imen),
        .vmen   (vmen),
        .tc     (tc),
        .cc     (cc),
        .cv     (cv),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [7:0] v, input logic [7:0] ib, input logic [7:0] tb);
        @(negedge clk);
        vbat    = v;
        ibat    = ib;
        tbat    = tb;
        smp_vld = 1'b1;
        @(posedge clk);
        #1;
        smp_vld = 1'b0;
    endtask

    task automatic test_reset;
        @(posedge clk);
        #1;
        expv = {6'b000000, 8'd0, 8'd0};
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("[TB] FAIL reset_state got %b exp %b", obs, expv);
        end
        @(negedge clk);
        rstz = 1'b1;
    endtask

    task automatic test_charge_ramp;
        en  = 1'b1;
        sel = 4'd1;
        applyStimulus(8'd120, 8'd50, 8'd100);
        expv = {6'b000000, 8'd0, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v1_start got %b exp %b", obs, expv); end
        applyStimulus(8'd120, 8'd50, 8'd100);
        expv = {6'b100010, 8'd2, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v1_tc got %b exp %b", obs, expv); end
        applyStimulus(8'd150, 8'd50, 8'd100);
        expv = {6'b010010, 8'd16, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v1_cc got %b exp %b", obs, expv); end
        @(negedge clk);
        vbat = 8'd210;
        @(posedge clk);
        #1;
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v1_no_strobe got %b exp %b", obs, expv); end
        applyStimulus(8'd180, 8'd40, 8'd100);
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v1_cc_hold got %b exp %b", obs, expv); end
        applyStimulus(8'd210, 8'd30, 8'd100);
        expv = {6'b001001, 8'd0, 8'd210};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v1_cv got %b exp %b", obs, expv); end
        applyStimulus(8'd210, 8'd3, 8'd100);
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v1_cv_ibat3 got %b exp %b", obs, expv); end
        applyStimulus(8'd210, 8'd2, 8'd100);
        expv = {6'b000100, 8'd0, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v1_done got %b exp %b", obs, expv); end
    endtask

    task automatic test_recharge;
        applyStimulus(8'd200, 8'd2, 8'd100);
        expv = {6'b000100, 8'd0, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v2_vrech_hold got %b exp %b", obs, expv); end
        applyStimulus(8'd199, 8'd2, 8'd100);
        expv = {6'b000000, 8'd0, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v2_restart got %b exp %b", obs, expv); end
        applyStimulus(8'd199, 8'd50, 8'd100);
        expv = {6'b010010, 8'd16, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v2_cc got %b exp %b", obs, expv); end
    endtask

    task automatic test_temperature;
        applyStimulus(8'd190, 8'd50, 8'd201);
        expv = {6'b000100, 8'd0, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v3_hot_end got %b exp %b", obs, expv); end
        applyStimulus(8'd190, 8'd50, 8'd200);
        expv = {6'b000000, 8'd0, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v3_tmax_restart got %b exp %b", obs, expv); end
        applyStimulus(8'd190, 8'd50, 8'd100);
        expv = {6'b010010, 8'd16, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v3_cc got %b exp %b", obs, expv); end
        applyStimulus(8'd190, 8'd50, 8'd19);
        expv = {6'b000100, 8'd0, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v3_cold_end got %b exp %b", obs, expv); end
        applyStimulus(8'd190, 8'd50, 8'd20);
        expv = {6'b000000, 8'd0, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v3_tmin_restart got %b exp %b", obs, expv); end
        applyStimulus(8'd190, 8'd50, 8'd20);
        expv = {6'b010010, 8'd16, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v3_cc_again got %b exp %b", obs, expv); end
    endtask

    task automatic test_sel_hold;
        @(negedge clk);
        sel = 4'd15;
        applyStimulus(8'd190, 8'd50, 8'd100);
        expv = {6'b010010, 8'd16, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v6_sel_ignored got %b exp %b", obs, expv); end
        applyStimulus(8'd190, 8'd50, 8'd250);
        expv = {6'b000100, 8'd0, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v6_end got %b exp %b", obs, expv); end
        applyStimulus(8'd190, 8'd50, 8'd100);
        expv = {6'b000000, 8'd0, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v6_start got %b exp %b", obs, expv); end
        applyStimulus(8'd120, 8'd50, 8'd100);
        expv = {6'b100010, 8'd16, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v6_tc_sel15 got %b exp %b", obs, expv); end
        applyStimulus(8'd160, 8'd50, 8'd100);
        expv = {6'b010010, 8'd128, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v6_cc_max got %b exp %b", obs, expv); end
    endtask

    task automatic test_cv_timer;
        applyStimulus(8'd210, 8'd50, 8'd100);
        expv = {6'b001001, 8'd0, 8'd210};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v5_cv_entry got %b exp %b", obs, expv); end
`ifdef BATCHARGER_CTRL_CVTIMER_EN
        for (int k = 1; k <= 9; k++) applyStimulus(8'd210, 8'd50, 8'd100);
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v5_cv_9th got %b exp %b", obs, expv); end
        applyStimulus(8'd210, 8'd50, 8'd100);
        expv = {6'b000100, 8'd0, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v5_timeout_10th got %b exp %b", obs, expv); end
`else
        for (int k = 1; k <= 20; k++) applyStimulus(8'd210, 8'd50, 8'd100);
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v5_no_timer got %b exp %b", obs, expv); end
`endif
    endtask

    task automatic test_enable_reset;
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        expv = {6'b000000, 8'd0, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v4_en_idle got %b exp %b", obs, expv); end
        en  = 1'b1;
        sel = 4'd1;
        applyStimulus(8'd160, 8'd50, 8'd100);
        applyStimulus(8'd160, 8'd50, 8'd100);
        expv = {6'b010010, 8'd16, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v4_cc got %b exp %b", obs, expv); end
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        expv = {6'b000000, 8'd0, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v4_en_cc_idle got %b exp %b", obs, expv); end
        en = 1'b1;
        applyStimulus(8'd200, 8'd50, 8'd100);
        applyStimulus(8'd200, 8'd50, 8'd100);
        applyStimulus(8'd210, 8'd50, 8'd100);
        expv = {6'b001001, 8'd0, 8'd210};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v4_cv got %b exp %b", obs, expv); end
        #2;
        rstz = 1'b0;
        #1;
        expv = {6'b000000, 8'd0, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v4_async_reset got %b exp %b", obs, expv); end
        @(negedge clk);
        rstz = 1'b1;
        applyStimulus(8'd120, 8'd50, 8'd100);
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v4_post_reset_start got %b exp %b", obs, expv); end
        applyStimulus(8'd120, 8'd50, 8'd100);
        expv = {6'b100010, 8'd2, 8'd0};
        checks++;
        if (obs !== expv) begin failures++; $display("[TB] FAIL v4_post_reset_tc got %b exp %b", obs, expv); end
    endtask

    initial begin
        rstz    = 1'b0;
        en      = 1'b0;
        sel     = 4'd0;
        smp_vld = 1'b0;
        vbat    = 8'd0;
        ibat    = 8'd0;
        tbat    = 8'd100;
        test_reset;
        test_charge_ramp;
        test_recharge;
        test_temperature;
        test_sel_hold;
        test_cv_timer;
        test_enable_reset;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
